spi_responder: RTL and testbench
================================

Name: spi_responder

Overview:
- SPI mode-0 slave: the far end of the link driven by our SPI master, usable as a W5500 stand-in in simulation and as a board-level responder.
- Oversamples sclk, scsn and mosi in the system clock domain.
- Received bytes are pushed into an rx FIFO (wdata/wr/full). Transmit bytes are popped from a tx FIFO (rdata/rd/empty), using the same FIFO handshake as the master side.
- Tracks frame boundaries, byte counts and overflow/underrun errors.

Parameters:
- DATA, 8, bits per SPI word; MSB first.
- DUMMY, 8'h00, byte shifted out on miso when no tx data is available.
- CNT_W, 16, width of byte_cnt.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master; CPOL=0.
- scsn  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data; 0 while deselected.
- wdata  out  DATA  received byte to rx FIFO.
- wr  out  1  one-cycle write strobe.
- full  in  1  rx FIFO full.
- rdata  in  DATA  tx FIFO data; valid the cycle after rd.
- rd  out  1  one-cycle read strobe.
- empty  in  1  tx FIFO empty.
- clr_err  in  1  clears ovf and unf.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when scsn deasserts.
- byte_cnt  out  CNT_W  complete bytes in the current/last frame.
- ovf  out  1  sticky: a received byte was dropped because full was high.
- unf  out  1  sticky: DUMMY was sent because no tx byte was available.
- hdr_addr  out  16  header address (optional feature).
- hdr_ctrl  out  8  header control byte (optional feature).
- hdr_valid  out  1  header captured pulse (optional feature).

Behaviour:
- Reset values: all outputs 0, including miso, wr, rd, busy, byte_cnt, ovf, unf, hdr_*. Synchronizer flops reset to sclk=0, scsn=1, mosi=0.
- Synchronization: two-flop synchronizers on all three SPI inputs. Edge detection uses the second stage against a third flop.
  - sclk rise: sample mosi.
  - sclk fall: shift miso.
  - Input-to-action latency is 3 clk.
- Timing requirements on the master: half-period of sclk and scsn-to-first-edge setup each ≥ 4 clk.
- State machine: IDLE, ACTIVE.
- IDLE:
  - busy=0, miso=0, bit_cnt=0.
  - Tx prefetch: if the hold register is empty and !empty, pulse rd; capture rdata next cycle into hold and set hold_valid.
  - Synchronized scsn falling → ACTIVE.
- Entering ACTIVE:
  - busy=1, byte_cnt=0.
  - tx_shift loads hold if hold_valid (clear hold_valid); otherwise loads DUMMY and sets unf.
  - miso = tx_shift[DATA-1] from the next cycle.
- ACTIVE, on sclk rise:
  - rx_shift <= {rx_shift[DATA-2:0], mosi}; bit_cnt++.
  - When bit_cnt reaches DATA: bit_cnt wraps to 0 and byte_cnt increments (saturating at all-ones).
  - Then, if !full: wdata = byte, wr=1 for exactly one cycle. If full: byte dropped, ovf=1.
- ACTIVE, on sclk fall:
  - If bit_cnt==0 (byte boundary): load tx_shift from hold, or DUMMY with unf=1.
  - Otherwise shift tx_shift left by one.
- Refill during ACTIVE: the hold register is refilled as in IDLE. At most one rd is outstanding; rd is never asserted while empty=1.
- Synchronized scsn rising in ACTIVE:
  - Go to IDLE, pulse frame_done, miso=0.
  - A partial rx byte (bit_cnt≠0) is discarded and not written.
  - A loaded but unsent tx byte is lost. A byte in hold is retained.
- Simultaneous events: clr_err in the same cycle as a new ovf/unf event → the flag stays 1 (set wins).
- Reset mid-frame: returns to IDLE immediately. No wr or rd is issued on the reset cycle.

Optional Feature:
SPI_RESP_HDR_EN
- With the macro, the first 3 bytes of each frame form a W5500-style header: addr[15:8], addr[7:0], ctrl.
  - Header bytes are not written to the rx FIFO. They still count in byte_cnt.
  - tx sends DUMMY during the header, with no pops and no unf.
  - After byte 3: hdr_addr/hdr_ctrl update and hdr_valid pulses one cycle.
  - If hdr_ctrl[2] (RWB)=1 (write): data bytes are pushed to the rx FIFO; tx stays DUMMY with no pops.
  - If RWB=0 (read): rx data bytes are discarded; tx pops from the FIFO.
  - Prefetch is inhibited until the RWB=0 decision.
- Without the macro: hdr_* are tied to 0; every byte is pushed and every tx byte is popped.

Decomposition:
- Package spi_resp_pkg contains:
  - state enum (IDLE, ACTIVE);
  - HDR_LEN=3;
  - RWB_BIT=2;
  - default DUMMY constant.
- One sub-module, spi_resp_sync: 2-FF synchronizers plus sclk rise/fall and scsn fall/rise pulse generation.

Test Plan:
- Frame of 2 bytes, mosi 8'hA5, 8'h3C; tx FIFO holds 8'h5A, 8'hC3 → wr pulses with A5 then 3C; master sees 5A, C3 on miso; byte_cnt=2; one frame_done pulse.
- tx FIFO empty, 1-byte frame → miso shifts 8'h00; unf=1. Pulse clr_err → unf=0.
- full=1 throughout a 1-byte frame of 8'hFF → no wr; ovf=1; byte_cnt=1.
- scsn rises after 5 bits → no wr; frame_done pulses; the next frame is byte-aligned and receives 8'h81 correctly.
- Reset asserted mid-byte → all outputs 0 immediately; the following frame behaves normally.
- With SPI_RESP_HDR_EN, frame 00 10 04 DE AD → hdr_addr=16'h0010, hdr_ctrl=8'h04, hdr_valid pulse, wr for DE and AD only. A read frame 00 10 00 xx with tx FIFO holding 8'h77 → 8'h77 on the 4th byte.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
package spi_resp_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Header layout: addr[15:8], addr[7:0], ctrl; ctrl[RWB_BIT]=1 means write
  localparam int unsigned HDR_LEN   = 3;
  localparam int unsigned RWB_BIT   = 2;
  localparam logic [7:0]  DUMMY_DEF = 8'h00;

endpackage

// File: rtl/spi_resp_sync.sv
// Two-flop synchronizers for sclk/scsn/mosi plus edge pulses taken from the
// second stage against a third flop.
// Ports: clk, rst (async active-low); sclk/scsn/mosi raw SPI inputs;
//        mosi_s synchronized data; *_rise_c/*_fall_c single-cycle edge pulses.
module spi_resp_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic scsn,
  input  logic mosi,
  output logic mosi_s,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic scsn_fall_c,
  output logic scsn_rise_c
);

  logic [2:0] sclk_q;
  logic [2:0] scsn_q;
  logic [1:0] mosi_q;

  // Idle bus values on reset so release never looks like an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= 3'b000;
      scsn_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      scsn_q <= {scsn_q[1:0], scsn};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign mosi_s      = mosi_q[1];
  assign sclk_rise_c =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_c = ~sclk_q[1] &  sclk_q[2];
  assign scsn_fall_c = ~scsn_q[1] &  scsn_q[2];
  assign scsn_rise_c =  scsn_q[1] & ~scsn_q[2];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 slave: oversampled sclk/scsn/mosi, rx bytes pushed to an rx FIFO,
// tx bytes prefetched from a tx FIFO into a one-byte hold register.
// Ports: clk, rst (async active-low); sclk/scsn/mosi/miso SPI pins;
//        wdata/wr/full rx FIFO; rdata/rd/empty tx FIFO (rdata valid cycle after rd);
//        clr_err clears sticky ovf/unf; busy, frame_done, byte_cnt frame status;
//        hdr_addr/hdr_ctrl/hdr_valid header capture.
// Optional: define SPI_RESP_HDR_EN for W5500-style 3-byte header handling;
//           otherwise hdr_* are tied low and every byte is pushed/popped.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int unsigned     DATA  = 8,
  parameter logic [DATA-1:0] DUMMY = DATA'(DUMMY_DEF),
  parameter int unsigned     CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             scsn,
  input  logic             mosi,
  output logic             miso,
  output logic [DATA-1:0]  wdata,
  output logic             wr,
  input  logic             full,
  input  logic [DATA-1:0]  rdata,
  output logic             rd,
  input  logic             empty,
  input  logic             clr_err,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             ovf,
  output logic             unf,
  output logic [15:0]      hdr_addr,
  output logic [7:0]       hdr_ctrl,
  output logic             hdr_valid
);

  localparam int unsigned BIT_W = $clog2(DATA);

  state_t           state, state_d;
  logic             mosi_s, sclk_rise_c, sclk_fall_c, scsn_fall_c, scsn_rise_c;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_d;
  logic [DATA-1:0]  rx_shift, rx_shift_d, tx_shift, tx_shift_d;
  logic [DATA-1:0]  hold, hold_d, wdata_d;
  logic             hold_valid, hold_valid_d, rd_pend;
  logic             rd_d, wr_d, miso_d, busy_d, frame_done_d, ovf_d, unf_d;
  logic             load_c, byte_done_c;
  logic             rx_en, tx_en;

  spi_resp_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .scsn        (scsn),
    .mosi        (mosi),
    .mosi_s      (mosi_s),
    .sclk_rise_c (sclk_rise_c),
    .sclk_fall_c (sclk_fall_c),
    .scsn_fall_c (scsn_fall_c),
    .scsn_rise_c (scsn_rise_c)
  );

`ifdef SPI_RESP_HDR_EN
  logic        rx_en_d, tx_en_d, hdr_valid_d;
  logic [1:0]  hdr_idx, hdr_idx_d;
  logic [15:0] hdr_buf, hdr_buf_d, hdr_addr_d;
  logic [7:0]  hdr_ctrl_d;
`else
  // Header disabled: data flows in both directions for every byte
  assign rx_en     = 1'b1;
  assign tx_en     = 1'b1;
  assign hdr_addr  = '0;
  assign hdr_ctrl  = '0;
  assign hdr_valid = 1'b0;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    byte_cnt_d   = byte_cnt;
    rx_shift_d   = rx_shift;
    tx_shift_d   = tx_shift;
    hold_d       = hold;
    hold_valid_d = hold_valid;
    wdata_d      = wdata;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    frame_done_d = 1'b0;
    ovf_d        = ovf & ~clr_err;
    unf_d        = unf & ~clr_err;
    load_c       = 1'b0;
    byte_done_c  = 1'b0;
`ifdef SPI_RESP_HDR_EN
    rx_en_d      = rx_en;
    tx_en_d      = tx_en;
    hdr_idx_d    = hdr_idx;
    hdr_buf_d    = hdr_buf;
    hdr_addr_d   = hdr_addr;
    hdr_ctrl_d   = hdr_ctrl;
    hdr_valid_d  = 1'b0;
`endif

    case (state)
      IDLE: begin
        bit_cnt_d = '0;
        if (scsn_fall_c) begin
          state_d    = ACTIVE;
          byte_cnt_d = '0;
          load_c     = 1'b1;
        end
      end
      ACTIVE: begin
        if (scsn_rise_c) begin
          // Partial rx byte and any loaded tx byte are dropped; hold survives
          state_d      = IDLE;
          frame_done_d = 1'b1;
          bit_cnt_d    = '0;
`ifdef SPI_RESP_HDR_EN
          rx_en_d      = 1'b0;
          tx_en_d      = 1'b0;
          hdr_idx_d    = '0;
`endif
        end else if (sclk_rise_c) begin
          rx_shift_d = {rx_shift[DATA-2:0], mosi_s};
          if (bit_cnt == BIT_W'(DATA - 1)) begin
            bit_cnt_d   = '0;
            byte_done_c = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end else if (sclk_fall_c) begin
          if (bit_cnt == '0) load_c = 1'b1;
          else               tx_shift_d = {tx_shift[DATA-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    // Completed byte: count, then header capture or rx FIFO push
    if (byte_done_c) begin
      if (byte_cnt != '1) byte_cnt_d = byte_cnt + CNT_W'(1);
`ifdef SPI_RESP_HDR_EN
      if (hdr_idx != 2'(HDR_LEN)) begin
        hdr_idx_d = hdr_idx + 2'd1;
        hdr_buf_d = {hdr_buf[7:0], 8'(rx_shift_d)};
        if (hdr_idx == 2'(HDR_LEN - 1)) begin
          hdr_addr_d  = hdr_buf;
          hdr_ctrl_d  = 8'(rx_shift_d);
          hdr_valid_d = 1'b1;
          rx_en_d     = rx_shift_d[RWB_BIT];
          tx_en_d     = ~rx_shift_d[RWB_BIT];
        end
      end else
`endif
      if (rx_en) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_d    = 1'b1;
          wdata_d = rx_shift_d;
        end
      end
    end

    // Byte-boundary tx load; DUMMY only flags underrun when tx is enabled
    if (load_c) begin
      if (tx_en && hold_valid) begin
        tx_shift_d   = hold;
        hold_valid_d = 1'b0;
      end else begin
        tx_shift_d = DUMMY;
        if (tx_en) unf_d = 1'b1;
      end
    end

    // Hold refill with at most one read in flight
    if (rd_pend) begin
      hold_d       = rdata;
      hold_valid_d = 1'b1;
    end else if (tx_en && !hold_valid && !rd && !empty) begin
      rd_d = 1'b1;
    end

    busy_d = (state_d == ACTIVE);
    miso_d = (state_d == ACTIVE) ? tx_shift_d[DATA-1] : 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      rd_pend    <= 1'b0;
      wdata      <= '0;
      wr         <= 1'b0;
      rd         <= 1'b0;
      miso       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_d;
      byte_cnt   <= byte_cnt_d;
      rx_shift   <= rx_shift_d;
      tx_shift   <= tx_shift_d;
      hold       <= hold_d;
      hold_valid <= hold_valid_d;
      rd_pend    <= rd;
      wdata      <= wdata_d;
      wr         <= wr_d;
      rd         <= rd_d;
      miso       <= miso_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      ovf        <= ovf_d;
      unf        <= unf_d;
    end
  end

`ifdef SPI_RESP_HDR_EN
  // Header capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_en     <= 1'b0;
      tx_en     <= 1'b0;
      hdr_idx   <= '0;
      hdr_buf   <= '0;
      hdr_addr  <= '0;
      hdr_ctrl  <= '0;
      hdr_valid <= 1'b0;
    end else begin
      rx_en     <= rx_en_d;
      tx_en     <= tx_en_d;
      hdr_idx   <= hdr_idx_d;
      hdr_buf   <= hdr_buf_d;
      hdr_addr  <= hdr_addr_d;
      hdr_ctrl  <= hdr_ctrl_d;
      hdr_valid <= hdr_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: bit-level SPI master, rx/tx FIFO
// models and a byte-level reference model of what each frame should produce.
`timescale 1ns/1ps
module tb_spi_responder;

  localparam int unsigned HALF = 6;
  localparam logic [7:0]  DMY  = 8'h00;
`ifdef SPI_RESP_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, sclk, scsn, mosi, full, clr_err;
  logic        miso, wr, rd, busy, frame_done, ovf, unf, hdr_valid;
  logic [7:0]  wdata, hdr_ctrl;
  logic [7:0]  rdata = 8'h00;
  logic        empty = 1'b1;
  logic [15:0] byte_cnt, hdr_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fd     = 0;
  int n_hv     = 0;

  logic [7:0] txq[$];      // tx FIFO contents seen by the DUT
  logic [7:0] rxq[$];      // bytes written by the DUT
  logic [7:0] mdl_tx[$];   // reference: tx bytes not yet consumed by the link
  logic       mdl_unf;
  logic [7:0] mo[8];
  logic [7:0] mi[8];
  logic [7:0] txb[8];

  always #5 clk = ~clk;

  spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .scsn       (scsn),
    .mosi       (mosi),
    .miso       (miso),
    .wdata      (wdata),
    .wr         (wr),
    .full       (full),
    .rdata      (rdata),
    .rd         (rd),
    .empty      (empty),
    .clr_err    (clr_err),
    .busy       (busy),
    .frame_done (frame_done),
    .byte_cnt   (byte_cnt),
    .ovf        (ovf),
    .unf        (unf),
    .hdr_addr   (hdr_addr),
    .hdr_ctrl   (hdr_ctrl),
    .hdr_valid  (hdr_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO models and pulse monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (wr)         rxq.push_back(wdata);
      if (frame_done) n_fd++;
      if (hdr_valid)  n_hv++;
      if (rd) begin
        chk("rd_nonempty", 32'(txq.size() != 0), 32'd1);
        if (txq.size() != 0) rdata = txq.pop_front();
      end
    end
    empty = (txq.size() == 0);
  end

  // One tx load as the spec describes it: next queued byte, else DUMMY + underrun
  function automatic logic [7:0] model_load(input logic en);
    if (!en) return DMY;
    if (mdl_tx.size() == 0) begin
      mdl_unf = 1'b1;
      return DMY;
    end
    return mdl_tx.pop_front();
  endfunction

  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    repeat (HALF) @(negedge clk);
    s    = miso;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic do_frame(input int bits);
    logic s;
    scsn = 1'b0;
    for (int i = 0; i < bits; i++) begin
      spi_bit(mo[i / 8][7 - (i % 8)], s);
      mi[i / 8][7 - (i % 8)] = s;
    end
    repeat (HALF) @(negedge clk);
    scsn = 1'b1;
    repeat (HALF + 4) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int bits, input int ntx, input logic full_v);
    int          done, rx0, fd0, hv0;
    logic        rx_en, tx_en, e_ovf;
    logic [7:0]  exp_mi[9];
    logic [7:0]  exp_w[$];
    logic [15:0] e_addr;
    logic [7:0]  e_ctrl;
    for (int i = 0; i < ntx; i++) begin
      txq.push_back(txb[i]);
      mdl_tx.push_back(txb[i]);
    end
    full    = full_v;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    repeat (6) @(negedge clk);
    rx0 = rxq.size();
    fd0 = n_fd;
    hv0 = n_hv;
    do_frame(bits);

    // Reference: a load at frame start and after every completed byte
    done    = bits / 8;
    mdl_unf = 1'b0;
    e_ovf   = 1'b0;
    e_addr  = '0;
    e_ctrl  = '0;
    rx_en   = !HDR;
    tx_en   = !HDR;
    exp_mi[0] = model_load(tx_en);
    for (int k = 0; k < done; k++) begin
      if (HDR && k < 3) begin
        if (k == 0) e_addr[15:8] = mo[k];
        if (k == 1) e_addr[7:0]  = mo[k];
        if (k == 2) begin
          e_ctrl = mo[k];
          rx_en  = mo[k][2];
          tx_en  = !mo[k][2];
        end
      end else if (rx_en) begin
        if (full_v) e_ovf = 1'b1;
        else        exp_w.push_back(mo[k]);
      end
      exp_mi[k + 1] = model_load(tx_en);
    end

    for (int k = 0; k < done; k++)
      chk($sformatf("%s_miso%0d", tag, k), 32'(mi[k]), 32'(exp_mi[k]));
    chk({tag, "_wrcnt"}, 32'(rxq.size() - rx0), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && rx0 + k < rxq.size(); k++)
      chk($sformatf("%s_wdata%0d", tag, k), 32'(rxq[rx0 + k]), 32'(exp_w[k]));
    chk({tag, "_bytecnt"}, 32'(byte_cnt), 32'(done));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, "_unf"}, 32'(unf), 32'(mdl_unf));
    chk({tag, "_fdone"}, 32'(n_fd - fd0), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_miso_idle"}, 32'(miso), 32'd0);
    if (HDR && done >= 3) begin
      chk({tag, "_haddr"}, 32'(hdr_addr), 32'(e_addr));
      chk({tag, "_hctrl"}, 32'(hdr_ctrl), 32'(e_ctrl));
      chk({tag, "_hvalid"}, 32'(n_hv - hv0), 32'd1);
    end else begin
      chk({tag, "_hvalid"}, 32'(n_hv - hv0), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_wr"}, 32'(wr), 32'd0);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    chk({tag, "_bytecnt"}, 32'(byte_cnt), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_unf"}, 32'(unf), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
    chk({tag, "_haddr"}, 32'(hdr_addr), 32'd0);
    chk({tag, "_hctrl"}, 32'(hdr_ctrl), 32'd0);
    chk({tag, "_hvalid"}, 32'(hdr_valid), 32'd0);
  endtask

  initial begin
    logic s;
    int   n;
    rst = 1'b0; sclk = 1'b0; scsn = 1'b1; mosi = 1'b0; full = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

`ifndef SPI_RESP_HDR_EN
    // Two-byte exchange with a primed tx FIFO
    mo[0] = 8'hA5; mo[1] = 8'h3C; txb[0] = 8'h5A; txb[1] = 8'hC3;
    run_frame("t1", 16, 2, 1'b0);
    chk("t1_mi0_const", 32'(mi[0]), 32'h5A);
    chk("t1_mi1_const", 32'(mi[1]), 32'hC3);

    // Empty tx FIFO: DUMMY out, underrun, then clear
    mo[0] = 8'($urandom);
    run_frame("t2", 8, 0, 1'b0);
    chk("t2_unf_const", 32'(unf), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    chk("t2_unf_clr", 32'(unf), 32'd0);

    // rx FIFO full: byte dropped, overflow
    mo[0] = 8'hFF;
    run_frame("t3", 8, 0, 1'b1);
    chk("t3_ovf_const", 32'(ovf), 32'd1);

    // Abort after 5 bits, then an aligned byte
    mo[0] = 8'($urandom);
    run_frame("t4a", 5, 0, 1'b0);
    mo[0] = 8'h81;
    run_frame("t4b", 8, 0, 1'b0);
    chk("t4_rx81", 32'(rxq[rxq.size() - 1]), 32'h81);
`else
    // Write frame: header then two data bytes
    mo[0] = 8'h00; mo[1] = 8'h10; mo[2] = 8'h04; mo[3] = 8'hDE; mo[4] = 8'hAD;
    run_frame("h1", 40, 0, 1'b0);
    chk("h1_addr_const", 32'(hdr_addr), 32'h0010);
    chk("h1_ctrl_const", 32'(hdr_ctrl), 32'h04);
    chk("h1_last_wr", 32'(rxq[rxq.size() - 1]), 32'hAD);

    // Read frame: tx byte appears on the 4th byte
    mo[0] = 8'h00; mo[1] = 8'h10; mo[2] = 8'h00; mo[3] = 8'($urandom); txb[0] = 8'h77;
    run_frame("h2", 32, 1, 1'b0);
    chk("h2_mi3_const", 32'(mi[3]), 32'h77);
`endif

    // Reset in the middle of a byte
    full = 1'b0;
    scsn = 1'b0;
    spi_bit(1'b1, s);
    spi_bit(1'b0, s);
    spi_bit(1'b1, s);
    chk("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    scsn = 1'b1;
    sclk = 1'b0;
    txq.delete();
    mdl_tx.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    mo[0] = 8'h96; mo[1] = 8'h00; mo[2] = 8'h00; mo[3] = 8'h5C; txb[0] = 8'h3E; txb[1] = 8'hB1;
    run_frame("post_rst", HDR ? 32 : 8, 2, 1'b0);

    // Randomized frames against the reference model
    for (int f = 0; f < 6; f++) begin
      n = HDR ? int'($urandom_range(3, 6)) : int'($urandom_range(1, 4));
      for (int i = 0; i < 8; i++) begin
        mo[i]  = 8'($urandom);
        txb[i] = 8'($urandom);
      end
      run_frame($sformatf("rnd%0d", f), n * 8, int'($urandom_range(0, n + 1)),
                ($urandom_range(0, 3) == 0));
    end

`ifndef SPI_RESP_HDR_EN
    chk("hdr_tied_addr", 32'(hdr_addr), 32'd0);
    chk("hdr_tied_hv", 32'(n_hv), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
